// File: rtl/uart_pkg.sv
// Shared definitions for the host-board UART blocks on the Z80 IO bus.
// Port numbers, receiver FSM states and status bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] UART_TX_DATA_PORT = 8'h00;
  localparam logic [7:0] UART_RX_DATA_PORT = 8'h01;
  localparam logic [7:0] UART_TX_STAT_PORT = 8'h02;
  localparam logic [7:0] UART_RX_STAT_PORT = 8'h03;

  localparam int ST_READY   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_FRAMING = 2;
  localparam int ST_FULL    = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for the UART receiver; push into a full FIFO is
// accepted only when a pop happens on the same clock.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic          wr_en, rd_en;

  always_comb begin
    rd_en  = pop && (cnt_q != '0);
    wr_en  = push && ((cnt_q != FULL_CNT) || rd_en);
    wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

  assign head  = mem_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;

endmodule

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver with byte FIFO, read through Z80 IO ports
// 0x01 (data, pops on access end) and 0x03 (status).
import uart_pkg::*;

module uart_rx_io #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic [7:0] Address,
  inout  wire  [7:0] Data,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  output logic       rx_int
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovr_q, ovr_d;
  logic            frm_q, frm_d;
  logic            data_acc_q, stat_acc_q;
  logic            data_acc, stat_acc;
  logic            push, frm_set, ovr_set;
  logic            pop, stat_end;
  logic            empty, full;
  logic [7:0]      head;
  logic [AW:0]     fifo_count;
  logic [7:0]      status, rd_data;
  logic            drive;
  logic            unused_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    frm_set = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          cnt_d   = HALF;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_sync_q) begin
          cnt_d   = FULL;
          bit_d   = '0;
          state_d = RX_DATA;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push    = rx_sync_q;
          frm_set = !rx_sync_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_acc = IORQ && RD && (Address == UART_RX_DATA_PORT);
  assign stat_acc = IORQ && RD && (Address == UART_RX_STAT_PORT);

  // Side effects land on the clock after the CPU lets go of the port.
  assign pop      = data_acc_q && !data_acc;
  assign stat_end = stat_acc_q && !stat_acc;
  assign ovr_set  = push && full && !pop;

  always_comb begin
    ovr_d = ovr_set || (ovr_q && !stat_end);
    frm_d = frm_set || (frm_q && !stat_end);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      data_acc_q <= 1'b0;
      stat_acc_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      data_acc_q <= data_acc;
      stat_acc_q <= stat_acc;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

  always_comb begin
    status              = 8'h00;
    status[ST_READY]    = !empty;
    status[ST_OVERRUN]  = ovr_q;
    status[ST_FRAMING]  = frm_q;
    status[ST_FULL]     = full;
  end

  always_comb begin
    drive   = 1'b0;
    rd_data = 8'h00;
    unique case (1'b1)
      data_acc: begin
        drive   = 1'b1;
        rd_data = empty ? 8'h00 : head;
      end
      stat_acc: begin
        drive   = 1'b1;
        rd_data = status;
      end
      default: ;
    endcase
  end

  assign Data      = drive ? rd_data : 8'hzz;
  assign rx_int    = !empty;
  assign unused_ok = ^{WR, fifo_count};

endmodule
